// File: rtl/mdu_sequencer_pkg.sv
// Shared types and MDU op encodings for the iterative multiply/divide sequencer.
// Encodings follow the RV32M funct3 ordering.
package mdu_sequencer_pkg;

    localparam int XLEN         = 32;
    localparam int ITER_CNT_W   = 5;
    localparam int MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

    typedef enum logic [2:0] {
        MDU_IDLE,
        MDU_PREP,
        MDU_CALC,
        MDU_FIX,
        MDU_DONE
    } mdu_state_t;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply, restoring divide.
// Optional MDU_ZERO_FAST_EN: zero operands skip the iteration phase.
//
// state    | meaning
// IDLE     | waiting for start_i; latches op and operands
// PREP     | magnitude of signed operands, sign flags, accumulator init
// CALC     | 32 iterations, counter runs 31..0
// FIX      | sign correction and result select into result_o
// DONE     | one-cycle valid_o pulse, pipeline released
module mdu_sequencer
    import mdu_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
    input  logic [XLEN-1:0]         op_a_i,
    input  logic [XLEN-1:0]         op_b_i,
    input  logic                    flush_i,
    output logic                    stall_o,
    output logic                    valid_o,
    output logic [XLEN-1:0]         result_o
);

    mdu_state_t              state_q, state_d;
    logic [MDU_OP_WIDTH-1:0] op_q;
    logic [XLEN-1:0]         a_q, b_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [ITER_CNT_W-1:0]   cnt_q;
    logic                    neg_q, neg_r, b_zero_q;

    logic            is_mul, signed_a, signed_b, sa, sb, skip_calc;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_part;
    logic [XLEN-1:0] div_rem;
    logic            div_ge;
    logic [XLEN-1:0] fix_result;

    assign is_mul   = ~op_q[2];
    assign signed_a = (op_q == MDU_MULH) || (op_q == MDU_MULHSU) ||
                      (op_q == MDU_DIV)  || (op_q == MDU_REM);
    assign signed_b = (op_q == MDU_MULH) || (op_q == MDU_DIV) || (op_q == MDU_REM);
    assign sa       = signed_a & a_q[XLEN-1];
    assign sb       = signed_b & b_q[XLEN-1];
    assign a_abs    = abs_val(a_q, sa);
    assign b_abs    = abs_val(b_q, sb);

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    // Shifted partial remainder can reach 33 bits before the trial subtract.
    assign div_part = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = (div_part >= {1'b0, b_q});
    assign div_rem  = div_part[XLEN-1:0] - b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MDU_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        valid_o   = 1'b0;
        skip_calc = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o = 1'b1;
                    state_d = MDU_PREP;
                end
            end
            MDU_PREP: begin
                stall_o = 1'b1;
`ifdef MDU_ZERO_FAST_EN
                skip_calc = (b_q == '0) || (is_mul && (a_q == '0));
`endif
                state_d = skip_calc ? MDU_FIX : MDU_CALC;
            end
            MDU_CALC: begin
                stall_o = 1'b1;
                if (cnt_q == '0) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                stall_o = 1'b1;
                state_d = MDU_DONE;
            end
            MDU_DONE: begin
                valid_o = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
        if (flush_i) state_d = MDU_IDLE;
    end

    always_comb begin
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   rem_mag;
        prod       = neg_q ? (~acc_q + 1'b1) : acc_q;
        rem_mag    = b_zero_q ? a_q : acc_q[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op_q)
            MDU_MUL:                          fix_result = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_result = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                fix_result = b_zero_q ? '1 :
                                                           abs_val(acc_q[XLEN-1:0], neg_q);
            default:                          fix_result = abs_val(rem_mag, neg_r);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero_q <= 1'b0;
            result_o <= '0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q <= mdu_op_i;
                        a_q  <= op_a_i;
                        b_q  <= op_b_i;
                    end
                end
                MDU_PREP: begin
                    a_q      <= a_abs;
                    b_q      <= b_abs;
                    neg_q    <= sa ^ sb;
                    neg_r    <= sa;
                    b_zero_q <= (b_q == '0);
                    cnt_q    <= '1;
                    if (is_mul) acc_q <= skip_calc ? '0 : {{XLEN{1'b0}}, b_abs};
                    else        acc_q <= {{XLEN{1'b0}}, a_abs};
                end
                MDU_CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_mul)      acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                    else if (div_ge) acc_q <= {div_rem, acc_q[XLEN-2:0], 1'b1};
                    else             acc_q <= {acc_q[2*XLEN-2:0], 1'b0};
                end
                MDU_FIX: result_o <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: latency, stall window, results, flush, reset.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start_i = 1'b0;
    logic [MDU_OP_WIDTH-1:0] mdu_op_i = '0;
    logic [XLEN-1:0]         op_a_i = '0;
    logic [XLEN-1:0]         op_b_i = '0;
    logic                    flush_i = 1'b0;
    logic                    stall_o, valid_o;
    logic [XLEN-1:0]         result_o;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef MDU_ZERO_FAST_EN
    localparam int ZERO_LAT = 3;
`else
    localparam int ZERO_LAT = 35;
`endif

    mdu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .mdu_op_i (mdu_op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one op, follows it to valid_o and checks latency, stall window, result, pulse width.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int stall_bad;
        step();
        start_i  = 1'b1;
        mdu_op_i = op;
        op_a_i   = a;
        op_b_i   = b;
        #1;
        stall_bad = (stall_o !== 1'b1) ? 1 : 0;
        step();
        start_i = 1'b0;
        cyc = 1;
        while (valid_o !== 1'b1 && cyc < 60) begin
            if (stall_o !== 1'b1) stall_bad++;
            step();
            cyc++;
        end
        tests_run++;
        if (cyc !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
        end
        tests_run++;
        if (result_o !== exp_res) begin
            tests_failed++;
            $display("FAIL %s result: got %h expected %h", name, result_o, exp_res);
        end
        tests_run++;
        if (stall_bad != 0 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s stall: %0d busy cycles low, done-cycle stall=%b expected 0",
                     name, stall_bad, stall_o);
        end
        step();
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s valid_pulse: got %b expected 0", name, valid_o);
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (stall_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset: stall=%b valid=%b result=%h expected 0 0 0",
                     stall_o, valid_o, result_o);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op("mul_7x6",   MDU_MUL,    32'd7,        32'd6,        32'd42,       35);
        run_op("mulh_m1",   MDU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35);
        run_op("mulhu_m1",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
        run_op("mulhsu_m1", MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
    endtask

    task automatic test_div();
        run_op("div_m7_2",  MDU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);
        run_op("rem_m7_2",  MDU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35);
        run_op("divu_100_7", MDU_DIVU, 32'd100,     32'd7, 32'd14,       35);
        run_op("remu_100_7", MDU_REMU, 32'd100,     32'd7, 32'd2,        35);
    endtask

    task automatic test_div_corner();
        run_op("div_5_0",   MDU_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, ZERO_LAT);
        run_op("rem_5_0",   MDU_REM, 32'd5,        32'd0,        32'd5,        ZERO_LAT);
        run_op("div_ovf",   MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35);
        run_op("rem_ovf",   MDU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 35);
        run_op("mul_0x9",   MDU_MUL, 32'd0,        32'd9,        32'd0,        ZERO_LAT);
    endtask

    task automatic test_flush();
        int seen;
        step();
        start_i  = 1'b1;
        mdu_op_i = MDU_MUL;
        op_a_i   = 32'd5;
        op_b_i   = 32'd5;
        step();
        start_i = 1'b0;
        repeat (11) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stall: got %b expected 0", stall_o);
        end
        seen = 0;
        repeat (40) begin
            if (valid_o === 1'b1) seen++;
            step();
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL flush_no_valid: got %0d pulses expected 0", seen);
        end
        run_op("mul_3x3_after_flush", MDU_MUL, 32'd3, 32'd3, 32'd9, 35);
    endtask

    task automatic test_async_reset();
        step();
        start_i  = 1'b1;
        mdu_op_i = MDU_DIVU;
        op_a_i   = 32'd1000;
        op_b_i   = 32'd3;
        step();
        start_i = 1'b0;
        repeat (8) step();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (stall_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL midop_reset: stall=%b valid=%b result=%h expected 0 0 0",
                     stall_o, valid_o, result_o);
        end
        step();
        rst_n = 1'b1;
        run_op("divu_9_3_after_reset", MDU_DIVU, 32'd9, 32'd3, 32'd3, 35);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_corner();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
